datapath_param: RTL
===================

# datapath_param

Parametrised single-bus CPU datapath: general register file, PC, IR, Y, 2×WIDTH Z (Zhigh/Zlow), HI, LO, MAR and MDR around one shared bus, with an ALU fed by Y and the bus. It extends the original fixed 32-bit, 16-register datapath in four ways:
- width and register count are configurable;
- bus source is priority-resolved, with conflict detection;
- signed multiply and divide are iterative, with a busy/done handshake;
- the divide-by-zero outcome is defined.

The control unit (or a testbench) drives it with per-register in/out strobes.

## Interface
Parameters:
- WIDTH, 32, datapath width; power of two, 8..64
- NREGS, 16, general registers R0..R(NREGS-1); 2..32

Ports:
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  reset, synchronous, active-low
- reg_in  in  NREGS  bit i loads R[i] from bus
- reg_out  in  NREGS  bit i drives R[i] onto bus
- pc_in, ir_in, y_in, hi_in, lo_in, mar_in, mdr_in  in  1 each  load strobes
- pc_out, hi_out, lo_out, zhi_out, zlo_out, mdr_out, c_out  in  1 each  bus drive requests
- imm  in  WIDTH  constant driven onto bus when c_out is selected
- read  in  1  MDR source select: 1 = mem_data, 0 = bus
- mem_data  in  WIDTH  memory read data
- z_in  in  1  latch ALU result into Z, or start MUL/DIV
- alu_op  in  4  operation, sampled with z_in
- bus  out  WIDTH  current bus value
- mar_q, ir_q, pc_q  out  WIDTH  register contents
- busy  out  1  iterative op in progress
- done  out  1  one-cycle pulse when MUL/DIV result is written
- div_by_zero  out  1  set with done on DIV by zero
- bus_conflict  out  1  more than one drive request asserted

## Operation
- Bus source: lowest asserted request wins, in priority order reg_out[0..NREGS-1], hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, c_out.
- If no request is asserted, bus = 0.
- bus_conflict is combinational; it is high when two or more requests are asserted, and the winner still drives the bus.
- Every *_in strobe loads its register from the bus at the edge; multiple loads in one cycle are allowed.
- mdr_in loads mem_data when read = 1, otherwise the bus.
- A register both driving and loading keeps its value.
- ALU operands: A = Y, B = bus. Shift amount = B[log2(WIDTH)-1:0].
- alu_op codes, all single-cycle (Zlo = result, Zhi = 0 unless noted):
  - 0 ADD, 1 SUB (A−B), 2 AND, 3 OR
  - 4 SHR logical, 5 SHRA, 6 SHL, 7 ROR, 8 ROL
  - 9 NEG(B), 10 NOT(B), 11 INC(B+1)
  - 14, 15 reserved: Z = 0
- All arithmetic is modulo 2^WIDTH; carries are discarded.
- 12 MUL: signed A×B, full 2×WIDTH product in {Zhi,Zlo}.
- 13 DIV: signed A÷B; Zlo = quotient truncated toward zero, Zhi = remainder with the dividend's sign.
- DIV by zero: Zlo = all ones, Zhi = A, div_by_zero = 1.
- div_by_zero stays high until the next z_in accept or reset.
- Iterative engine: shift-add / restoring, one bit per cycle.
  - Operands are captured at the z_in edge.
  - Sign correction is applied at completion.
- Reset (clr = 0 at an edge):
  - all registers, Z, busy, done and div_by_zero go to 0;
  - any MUL/DIV in progress is aborted and no result is written.

## Timing
- Single-cycle op: z_in at edge k → Z valid after edge k. busy and done are not asserted.
- MUL/DIV accepted at edge k (busy = 0):
  - busy = 1 after edge k;
  - Z is written, done = 1 and busy = 0 after edge k+WIDTH;
  - done drops after edge k+WIDTH+1.
- z_in while busy = 1 is ignored; Z and the engine are unaffected.
- z_in in the cycle done is high is accepted normally.
- While busy, zhi_out/zlo_out drive the previous Z value, and all other transfers proceed normally.
- Y changes during busy do not affect the result.
- bus, bus_conflict, mar_q, ir_q and pc_q reflect register state combinationally; there is no output latency.

## Test plan
- Reset: load R3 = 0x1234, then hold clr = 0 for one edge → every register, Z, busy, done and div_by_zero read 0.
- Transfer and priority:
  - imm = 0xA5A5A5A5, c_out + reg_in[5] → R5 = 0xA5A5A5A5.
  - Then assert reg_out[5] and pc_out together → bus = 0xA5A5A5A5, bus_conflict = 1.
- Single-cycle ALU:
  - Y = 7, bus = 0xFFFFFFFE, ADD → Zlo = 5, Zhi = 0.
  - Y = 0x80000001, bus = 1, ROR → Zlo = 0xC0000000.
- MUL:
  - Y = −3, bus = 5, z_in at edge k → busy for 32 cycles; done after edge k+32 with {Zhi,Zlo} = 0xFFFFFFFF_FFFFFFF1.
  - A second z_in at k+10 is ignored.
- DIV:
  - Y = −7, bus = 2 → Zlo = 0xFFFFFFFD (−3), Zhi = 0xFFFFFFFF (−1).
  - Y = 9, bus = 0 → Zlo = 0xFFFFFFFF, Zhi = 9, div_by_zero = 1.
- Abort and memory read:
  - clr = 0 at k+16 of a MUL → busy = 0, no done pulse, Z = 0.
  - read = 1, mem_data = 0xDEADBEEF, mdr_in, then mdr_out + ir_in → ir_q = 0xDEADBEEF.

Source files
------------

// File: rtl/datapath_param.sv
// Single-bus CPU datapath: register file, PC/IR/Y/Z/HI/LO/MAR/MDR around one
// priority-resolved bus, with an ALU and an iterative signed MUL/DIV engine.
module datapath_param #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [NREGS-1:0] reg_in,
  input  logic [NREGS-1:0] reg_out,
  input  logic             pc_in,
  input  logic             ir_in,
  input  logic             y_in,
  input  logic             hi_in,
  input  logic             lo_in,
  input  logic             mar_in,
  input  logic             mdr_in,
  input  logic             pc_out,
  input  logic             hi_out,
  input  logic             lo_out,
  input  logic             zhi_out,
  input  logic             zlo_out,
  input  logic             mdr_out,
  input  logic             c_out,
  input  logic [WIDTH-1:0] imm,
  input  logic             read,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             z_in,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] mar_q,
  output logic [WIDTH-1:0] ir_q,
  output logic [WIDTH-1:0] pc_q,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             bus_conflict
);

  localparam int unsigned SW   = $clog2(WIDTH);
  localparam int unsigned NREQ = NREGS + 7;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpShr  = 4'd4;
  localparam logic [3:0] OpShra = 4'd5;
  localparam logic [3:0] OpShl  = 4'd6;
  localparam logic [3:0] OpRor  = 4'd7;
  localparam logic [3:0] OpRol  = 4'd8;
  localparam logic [3:0] OpNeg  = 4'd9;
  localparam logic [3:0] OpNot  = 4'd10;
  localparam logic [3:0] OpInc  = 4'd11;
  localparam logic [3:0] OpMul  = 4'd12;
  localparam logic [3:0] OpDiv  = 4'd13;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] hi_q, lo_q, y_q, mdr_q;
  logic [WIDTH-1:0] z_hi_q, z_hi_d, z_lo_q, z_lo_d;

  // Iterative engine state
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic             op_div_q, op_div_d, neg_q, neg_d, zero_q, zero_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_mag_q, b_mag_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;

  // ---------------------------------------------------------------------------
  // Bus: bit 0 of req has the highest priority
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0] req;
  logic            bus_found;

  assign req          = {c_out, mdr_out, pc_out, zlo_out, zhi_out, lo_out, hi_out, reg_out};
  assign bus_conflict = |(req & (req - NREQ'(1)));

  always_comb begin
    bus       = '0;
    bus_found = 1'b0;
    for (int i = 0; i < int'(NREGS); i++) begin
      if (!bus_found && reg_out[i]) begin
        bus       = regs_q[i];
        bus_found = 1'b1;
      end
    end
    if (!bus_found) begin
      if (hi_out)       bus = hi_q;
      else if (lo_out)  bus = lo_q;
      else if (zhi_out) bus = z_hi_q;
      else if (zlo_out) bus = z_lo_q;
      else if (pc_out)  bus = pc_q;
      else if (mdr_out) bus = mdr_q;
      else if (c_out)   bus = imm;
    end
  end

  // ---------------------------------------------------------------------------
  // Single-cycle ALU: A = Y, B = bus
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   alu_res;
  logic [SW-1:0]      shamt;
  logic [2*WIDTH-1:0] rot_tmp;

  assign shamt = bus[SW-1:0];

  always_comb begin
    alu_res = '0;
    rot_tmp = '0;
    case (alu_op)
      OpAdd:  alu_res = y_q + bus;
      OpSub:  alu_res = y_q - bus;
      OpAnd:  alu_res = y_q & bus;
      OpOr:   alu_res = y_q | bus;
      OpShr:  alu_res = y_q >> shamt;
      OpShra: alu_res = $signed(y_q) >>> shamt;
      OpShl:  alu_res = y_q << shamt;
      OpRor: begin
        rot_tmp = {y_q, y_q} >> shamt;
        alu_res = rot_tmp[WIDTH-1:0];
      end
      OpRol: begin
        rot_tmp = {y_q, y_q} << shamt;
        alu_res = rot_tmp[2*WIDTH-1:WIDTH];
      end
      OpNeg:  alu_res = -bus;
      OpNot:  alu_res = ~bus;
      OpInc:  alu_res = bus + WIDTH'(1);
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // MUL/DIV step logic on unsigned magnitudes; signs are re-applied at the end
  // ---------------------------------------------------------------------------
  logic             accept, is_iter, last;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_rsh, div_diff;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem, fin_hi, fin_lo;

  assign accept  = z_in && !busy_q;
  assign is_iter = (alu_op == OpMul) || (alu_op == OpDiv);
  assign last    = (cnt_q == SW'(WIDTH - 1));
  assign a_mag   = y_q[WIDTH-1] ? -y_q : y_q;
  assign b_mag   = bus[WIDTH-1] ? -bus : bus;

  always_comb begin
    mul_sum  = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, b_mag_q} : '0);
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], p_lo_q[WIDTH-1:1]};

    div_rsh  = {p_hi_q, p_lo_q[WIDTH-1]};
    div_diff = div_rsh - {1'b0, b_mag_q};
    div_hi_n = div_diff[WIDTH] ? div_rsh[WIDTH-1:0] : div_diff[WIDTH-1:0];
    div_lo_n = {p_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};

    prod = {mul_hi_n, mul_lo_n};
    if (neg_q) prod = -prod;
    quo = neg_q ? -div_lo_n : div_lo_n;
    rem = a_q[WIDTH-1] ? -div_hi_n : div_hi_n;

    if (!op_div_q) begin
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end else if (zero_q) begin
      fin_hi = a_q;
      fin_lo = '1;
    end else begin
      fin_hi = rem;
      fin_lo = quo;
    end
  end

  always_comb begin
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    op_div_d = op_div_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_mag_d  = b_mag_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    z_hi_d   = z_hi_q;
    z_lo_d   = z_lo_q;
    if (accept) begin
      dbz_d = 1'b0;
      if (is_iter) begin
        busy_d   = 1'b1;
        cnt_d    = '0;
        op_div_d = (alu_op == OpDiv);
        neg_d    = y_q[WIDTH-1] ^ bus[WIDTH-1];
        zero_d   = (bus == '0);
        a_d      = y_q;
        b_mag_d  = b_mag;
        p_hi_d   = '0;
        p_lo_d   = a_mag;
      end else begin
        z_hi_d = '0;
        z_lo_d = alu_res;
      end
    end else if (busy_q) begin
      cnt_d  = cnt_q + SW'(1);
      p_hi_d = op_div_q ? div_hi_n : mul_hi_n;
      p_lo_d = op_div_q ? div_lo_n : mul_lo_n;
      if (last) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        dbz_d  = op_div_q && zero_q;
        z_hi_d = fin_hi;
        z_lo_d = fin_lo;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
      pc_q     <= '0;
      ir_q     <= '0;
      y_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mar_q    <= '0;
      mdr_q    <= '0;
      z_hi_q   <= '0;
      z_lo_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      op_div_q <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_mag_q  <= '0;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
    end else begin
      // A register that drives the bus while loading keeps its own value
      for (int i = 0; i < int'(NREGS); i++) begin
        if (reg_in[i] && !reg_out[i]) regs_q[i] <= bus;
      end
      if (pc_in && !pc_out) pc_q <= bus;
      if (hi_in && !hi_out) hi_q <= bus;
      if (lo_in && !lo_out) lo_q <= bus;
      if (ir_in)            ir_q <= bus;
      if (y_in)             y_q  <= bus;
      if (mar_in)           mar_q <= bus;
      if (mdr_in) begin
        if (read)          mdr_q <= mem_data;
        else if (!mdr_out) mdr_q <= bus;
      end
      z_hi_q   <= z_hi_d;
      z_lo_q   <= z_lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      op_div_q <= op_div_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_mag_q  <= b_mag_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
